// File: rtl/odesa_pkg.sv
// Shared types and elaboration helpers for the ODESA layer.
// The optional learning path is enabled by defining ODESA_LEARN_EN.
package odesa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCORE,
        DECIDE,
        FIRE,
        LEARN
    } state_t;

    localparam logic CFG_SEL_WEIGHT = 1'b0;
    localparam logic CFG_SEL_THR    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Index/address width that never collapses to zero bits
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Dot product of n_in products of two width-bit operands cannot overflow this
    function automatic int score_width(input int width, input int n_in);
        return 2 * width + clog2(n_in);
    endfunction

endpackage

// File: rtl/odesa_trace_bank.sv
// Per-input time-surface traces: an event loads the maximum, otherwise every
// P_DECAY_DIV edges each trace decrements, saturating at zero.
module odesa_trace_bank
    import odesa_pkg::*;
#(
    parameter int P_N_IN      = 8,
    parameter int P_WIDTH     = 9,
    parameter int P_DECAY_DIV = 16
)(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [P_N_IN-1:0]           i_event,
    output logic [P_N_IN*P_WIDTH-1:0]   o_traces
);

    localparam int PW = addr_width(P_DECAY_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(P_DECAY_DIV - 1);

    logic [PW-1:0] prescaler_reg;
    logic          decay_tick;

    assign decay_tick = (prescaler_reg == PRE_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescaler_reg <= '0;
        end else if (decay_tick) begin
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < P_N_IN; gi++) begin : g_trace
            logic [P_WIDTH-1:0] trace_reg;

            // A fresh event takes priority over a decay tick on the same edge
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    trace_reg <= '0;
                end else if (i_event[gi]) begin
                    trace_reg <= '1;
                end else if (decay_tick && (trace_reg != '0)) begin
                    trace_reg <= trace_reg - 1'b1;
                end
            end

            assign o_traces[gi*P_WIDTH +: P_WIDTH] = trace_reg;
        end
    endgenerate

endmodule

// File: rtl/odesa_layer_p.sv
// ODESA event-driven layer: decaying traces, sequential per-neuron dot product and a
// thresholded winner-take-all spike. Define ODESA_LEARN_EN to add the on-line LEARN state.
module odesa_layer_p
    import odesa_pkg::*;
#(
    parameter int P_N_IN      = 8,
    parameter int P_N_NEURON  = 4,
    parameter int P_WIDTH     = 9,
    parameter int P_DECAY_DIV = 16,
    parameter int P_THR_INIT  = 1000,
    parameter int P_W_INIT    = 0,
    parameter int P_ETA_SH    = 3,
    parameter int P_THR_DEC   = 1,
    localparam int SW = score_width(P_WIDTH, P_N_IN),
    localparam int AW = addr_width(P_N_IN * P_N_NEURON)
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [P_N_IN-1:0]       i_event,
    input  logic                    i_cfg_we,
    input  logic                    i_cfg_sel,
    input  logic [AW-1:0]           i_cfg_addr,
    input  logic [SW-1:0]           i_cfg_data,
    output logic [P_N_NEURON-1:0]   o_spike_out,
    output logic                    o_busy
);

    localparam int IW = addr_width(P_N_NEURON);

    state_t                                 state_reg, state_next;
    logic                                   pend_reg;
    logic                                   leave_idle;
    logic                                   cfg_ok;
    logic [IW-1:0]                          idx_reg;
    logic [P_N_IN*P_WIDTH-1:0]              traces;
    logic [P_N_IN*P_WIDTH-1:0]              snap_reg;
    logic [P_N_NEURON*P_N_IN*P_WIDTH-1:0]   w_flat;
    logic [P_N_NEURON*SW-1:0]               thr_flat;
    logic [SW-1:0]                          score_reg [P_N_NEURON];
    logic [SW-1:0]                          row_score;
    logic [P_N_NEURON-1:0]                  spike_reg;
    logic                                   win_found;
    logic [IW-1:0]                          win_idx;
    logic [SW-1:0]                          win_score;
`ifdef ODESA_LEARN_EN
    logic                                   win_valid_reg;
    logic [IW-1:0]                          win_idx_reg;
`endif

    odesa_trace_bank #(
        .P_N_IN      (P_N_IN),
        .P_WIDTH     (P_WIDTH),
        .P_DECAY_DIV (P_DECAY_DIV)
    ) u_trace_bank (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_event  (i_event),
        .o_traces (traces)
    );

    assign leave_idle  = (state_reg == IDLE) && pend_reg;
    // Config is only safe while nothing reads weights/thresholds this edge or later
    assign cfg_ok      = i_cfg_we && (state_reg == IDLE) && !pend_reg;
    assign o_busy      = (state_reg != IDLE);
    assign o_spike_out = spike_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (pend_reg) state_next = SCORE;
            SCORE:  if (idx_reg == IW'(P_N_NEURON - 1)) state_next = DECIDE;
            DECIDE: state_next = FIRE;
`ifdef ODESA_LEARN_EN
            FIRE:   state_next = LEARN;
`else
            FIRE:   state_next = IDLE;
`endif
            LEARN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Events arriving on the departure edge re-arm the next evaluation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= (pend_reg && !leave_idle) || (|i_event);
        end
    end

    always_comb begin
        row_score = '0;
        for (int k = 0; k < P_N_IN; k++) begin
            row_score = row_score
                + SW'(snap_reg[k*P_WIDTH +: P_WIDTH])
                * SW'(w_flat[(int'(idx_reg) * P_N_IN + k) * P_WIDTH +: P_WIDTH]);
        end
    end

    // Strict '>' keeps the lowest index on equal scores
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_score = '0;
        for (int n = 0; n < P_N_NEURON; n++) begin
            if ((score_reg[n] >= thr_flat[n*SW +: SW]) &&
                (!win_found || (score_reg[n] > win_score))) begin
                win_found = 1'b1;
                win_idx   = IW'(n);
                win_score = score_reg[n];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_reg   <= '0;
            snap_reg  <= '0;
            spike_reg <= '0;
            for (int n = 0; n < P_N_NEURON; n++) score_reg[n] <= '0;
`ifdef ODESA_LEARN_EN
            win_valid_reg <= 1'b0;
            win_idx_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pend_reg) begin
                        snap_reg <= traces;
                        idx_reg  <= '0;
                    end
                end
                SCORE: begin
                    score_reg[idx_reg] <= row_score;
                    idx_reg            <= idx_reg + 1'b1;
                end
                DECIDE: begin
                    spike_reg <= win_found ? (P_N_NEURON'(1) << win_idx) : '0;
`ifdef ODESA_LEARN_EN
                    win_valid_reg <= win_found;
                    win_idx_reg   <= win_idx;
`endif
                end
                FIRE: begin
                    spike_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    genvar gi, gk;
    generate
        for (gi = 0; gi < P_N_NEURON; gi++) begin : g_neuron
            logic [SW-1:0] thr_reg;
`ifdef ODESA_LEARN_EN
            logic signed [SW:0] thr_diff;
            logic [SW-1:0]      thr_learned;
            logic               is_winner;

            assign is_winner   = win_valid_reg && (win_idx_reg == IW'(gi));
            assign thr_diff    = $signed({1'b0, score_reg[gi]}) - $signed({1'b0, thr_reg});
            assign thr_learned = SW'($signed({1'b0, thr_reg}) + (thr_diff >>> P_ETA_SH));
`endif

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    thr_reg <= SW'(P_THR_INIT);
                end else if (cfg_ok && (i_cfg_sel == CFG_SEL_THR) && (i_cfg_addr == AW'(gi))) begin
                    thr_reg <= i_cfg_data;
`ifdef ODESA_LEARN_EN
                end else if (state_reg == LEARN) begin
                    if (is_winner) begin
                        thr_reg <= thr_learned;
                    end else if (!win_valid_reg) begin
                        thr_reg <= (thr_reg > SW'(P_THR_DEC)) ? thr_reg - SW'(P_THR_DEC) : '0;
                    end
`endif
                end
            end

            assign thr_flat[gi*SW +: SW] = thr_reg;

            for (gk = 0; gk < P_N_IN; gk++) begin : g_input
                logic [P_WIDTH-1:0] w_reg;
`ifdef ODESA_LEARN_EN
                logic signed [P_WIDTH:0] w_diff;
                logic [P_WIDTH-1:0]      w_learned;

                assign w_diff    = $signed({1'b0, snap_reg[gk*P_WIDTH +: P_WIDTH]}) - $signed({1'b0, w_reg});
                assign w_learned = P_WIDTH'($signed({1'b0, w_reg}) + (w_diff >>> P_ETA_SH));
`endif

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        w_reg <= P_WIDTH'(P_W_INIT);
                    end else if (cfg_ok && (i_cfg_sel == CFG_SEL_WEIGHT) &&
                                 (i_cfg_addr == AW'(gi * P_N_IN + gk))) begin
                        w_reg <= i_cfg_data[P_WIDTH-1:0];
`ifdef ODESA_LEARN_EN
                    end else if ((state_reg == LEARN) && is_winner) begin
                        w_reg <= w_learned;
`endif
                    end
                end

                assign w_flat[(gi * P_N_IN + gk) * P_WIDTH +: P_WIDTH] = w_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_odesa_layer_p.sv
// Self-checking bench for odesa_layer_p: directed scenarios plus random events/config
// compared each cycle against an evaluation-level model (honours ODESA_LEARN_EN).
module tb_odesa_layer_p;

    localparam int N_IN     = 8;
    localparam int N_NEU    = 4;
    localparam int WID      = 9;
    localparam int DIV      = 16;
    localparam int THR_INIT = 1000;
    localparam int ETA      = 3;
    localparam int THR_DEC  = 1;
    localparam int SW       = 2 * WID + $clog2(N_IN);
    localparam int AW       = $clog2(N_IN * N_NEU);
    localparam int TMAX     = (1 << WID) - 1;
    localparam int SPIKE_AGE = N_NEU + 1;
`ifdef ODESA_LEARN_EN
    localparam int BUSY_LAST = N_NEU + 2;
`else
    localparam int BUSY_LAST = N_NEU + 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_IN-1:0]   ev_in = '0;
    logic              cfg_we = 1'b0;
    logic              cfg_sel = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [SW-1:0]     cfg_data = '0;
    logic [N_NEU-1:0]  spike_out;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_trace [N_IN];
    int m_w     [N_NEU][N_IN];
    int m_thr   [N_NEU];
    int m_edges;
    bit m_pend;
    int m_age;
    int m_win;
    int spike_cnt;
    int last_spike;

    always #5 clk = ~clk;

    odesa_layer_p #(
        .P_N_IN(N_IN), .P_N_NEURON(N_NEU), .P_WIDTH(WID), .P_DECAY_DIV(DIV),
        .P_THR_INIT(THR_INIT), .P_W_INIT(0), .P_ETA_SH(ETA), .P_THR_DEC(THR_DEC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_event(ev_in),
        .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .o_spike_out(spike_out), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_IN; k++) m_trace[k] = 0;
        for (int n = 0; n < N_NEU; n++) begin
            m_thr[n] = THR_INIT;
            for (int k = 0; k < N_IN; k++) m_w[n][k] = 0;
        end
        m_edges = 0;
        m_pend  = 0;
        m_age   = -1;
        m_win   = -1;
    endtask

    // One clock edge of the reference: evaluation is resolved whole at its start
    task automatic model_edge(input logic [N_IN-1:0] ev, input logic we, input logic sel,
                              input logic [AW-1:0] addr, input logic [SW-1:0] data);
        bit was_idle;
        int sc, best, best_sc;
        was_idle = (m_age < 0);
        m_edges++;
        if (m_age >= 0) begin
            m_age++;
            if (m_age > BUSY_LAST) m_age = -1;
        end
        if (was_idle && m_pend) begin
            best = -1;
            best_sc = 0;
            for (int n = 0; n < N_NEU; n++) begin
                sc = 0;
                for (int k = 0; k < N_IN; k++) sc += m_trace[k] * m_w[n][k];
                if (sc >= m_thr[n] && (best < 0 || sc > best_sc)) begin
                    best = n;
                    best_sc = sc;
                end
            end
            m_win  = best;
            m_age  = 0;
            m_pend = 0;
`ifdef ODESA_LEARN_EN
            if (best >= 0) begin
                m_thr[best] += (best_sc - m_thr[best]) >>> ETA;
                for (int k = 0; k < N_IN; k++) m_w[best][k] += (m_trace[k] - m_w[best][k]) >>> ETA;
            end else begin
                for (int n = 0; n < N_NEU; n++) m_thr[n] = (m_thr[n] > THR_DEC) ? m_thr[n] - THR_DEC : 0;
            end
`endif
        end else if (was_idle && we) begin
            if (sel == 1'b0) begin
                if (int'(addr) < N_IN * N_NEU) m_w[int'(addr) / N_IN][int'(addr) % N_IN] = int'(data) & TMAX;
            end else if (int'(addr) < N_NEU) begin
                m_thr[int'(addr)] = int'(data);
            end
        end
        if (ev != '0) m_pend = 1;
        for (int k = 0; k < N_IN; k++) begin
            if (ev[k]) m_trace[k] = TMAX;
            else if ((m_edges % DIV == 0) && m_trace[k] > 0) m_trace[k]--;
        end
    endtask

    task automatic step(input logic [N_IN-1:0] ev, input logic we = 1'b0, input logic sel = 1'b0,
                        input logic [AW-1:0] addr = '0, input logic [SW-1:0] data = '0);
        int exp_spike;
        ev_in = ev; cfg_we = we; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        @(posedge clk);
        model_edge(ev, we, sel, addr, data);
        #1;
        exp_spike = (m_age == SPIKE_AGE && m_win >= 0) ? (1 << m_win) : 0;
        check("spike", 32'(spike_out), 32'(exp_spike));
        check("busy", 32'(busy), 32'(m_age >= 0));
        if (spike_out != '0) begin
            spike_cnt++;
            last_spike = int'(spike_out);
        end
        ev_in = '0; cfg_we = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    initial begin
        logic [N_IN-1:0] rev;
        logic            rsel;
        logic [AW-1:0]   raddr;
        logic [SW-1:0]   rdata;

        model_reset();
        spike_cnt = 0;
        last_spike = 0;

        // T1: reset state held, then long idle run
        for (int i = 0; i < 10; i++) begin
            #1;
            check("rst_spike", 32'(spike_out), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            #9;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_steps(1000);

        // T2: single strong weight, first-event latency
        step('0, 1'b1, 1'b0, AW'(2 * N_IN + 0), SW'(511));
        idle_steps(2);
        step(8'h01);
        idle_steps(6);
        check("t2_spike", 32'(spike_out), 32'b0100);
        step('0);
        check("t2_one_cycle", 32'(spike_out), 32'd0);
        idle_steps(10);

        // T3: threshold just above the decayed score
        step('0, 1'b1, 1'b1, AW'(2), SW'(256012));
        idle_steps(160);
        step(8'h08);
        for (int i = 0; i < 10; i++) begin
            step('0);
            check("t3_nospike", 32'(spike_out), 32'd0);
        end

        // T4: equal rows 1 and 3, lowest index wins
        step('0, 1'b1, 1'b1, AW'(2), SW'(256012));
        step('0, 1'b1, 1'b0, AW'(1 * N_IN + 4), SW'(100));
        step('0, 1'b1, 1'b0, AW'(3 * N_IN + 4), SW'(100));
        step(8'h10);
        idle_steps(6);
        check("t4_tie", 32'(spike_out), 32'b0010);
        idle_steps(10);

        // T5: second event during SCORE, config write while busy is dropped
        spike_cnt = 0;
        step(8'h01);
        step('0);
        step(8'h02, 1'b1, 1'b0, AW'(0), SW'(511));
        idle_steps(25);
        check("t5_spike_count", 32'(spike_cnt), 32'd2);
        check("t5_last_spike", 32'(last_spike), 32'b0100);

`ifdef ODESA_LEARN_EN
        // T6: unreachable thresholds, no spike (thresholds then decay)
        for (int n = 0; n < N_NEU; n++) step('0, 1'b1, 1'b1, AW'(n), {SW{1'b1}});
        step(8'hFF);
        for (int i = 0; i < 10; i++) begin
            step('0);
            check("t6_nospike", 32'(spike_out), 32'd0);
        end
`endif

        // Reset asserted during SCORE aborts the evaluation
        step(8'h01);
        step('0);
        step('0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_spike", 32'(spike_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step('0);
            check("abort_quiet", 32'(spike_out), 32'd0);
        end

        // Random events and config traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rev = ($urandom_range(0, 9) == 0) ? N_IN'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) begin
                rsel = 1'($urandom);
                if (rsel) begin
                    raddr = AW'($urandom_range(0, 7));
                    rdata = SW'($urandom_range(0, 300000));
                end else begin
                    raddr = AW'($urandom_range(0, N_IN * N_NEU - 1));
                    rdata = SW'($urandom);
                end
                step(rev, 1'b1, rsel, raddr, rdata);
            end else begin
                step(rev);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
